// File: rtl/conv_tap_sequencer.sv
// conv_tap_sequencer
//   Row-major scan controller for a 3x3 zero-padded convolution over an
//   IMG_W x IMG_W image. For every output pixel it issues the nine kernel-tap
//   read addresses, tags each returned sample for the MAC datapath one cycle
//   later, then waits for the datapath to acknowledge the pixel writeback.
//   Build option: define CONV_SKIP_PAD_EN to drop out-of-range taps instead of
//   issuing them with tap_pad set.
module conv_tap_sequencer #(
  parameter int IMG_W  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] iaddr,
  output logic              tap_vld,
  output logic [3:0]        tap_idx,
  output logic              tap_pad,
  output logic              tap_first,
  output logic              tap_last,
  output logic              wb_req,
  input  logic              wb_ack,
  output logic [ADDR_W-1:0] pix_addr
);

  localparam int               CRD_W   = $clog2(IMG_W);
  localparam logic [CRD_W-1:0] LP_EDGE = CRD_W'(IMG_W - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_WB_WAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Kernel index k -> {row select, col select}; select 0/1/2 means offset -1/0/+1.
  function automatic logic [3:0] k_sel(input logic [3:0] k);
    logic [3:0] sel;
    case (k)
      4'd0:    sel = 4'b00_00;
      4'd1:    sel = 4'b00_01;
      4'd2:    sel = 4'b00_10;
      4'd3:    sel = 4'b01_00;
      4'd4:    sel = 4'b01_01;
      4'd5:    sel = 4'b01_10;
      4'd6:    sel = 4'b10_00;
      4'd7:    sel = 4'b10_01;
      default: sel = 4'b10_10;
    endcase
    return sel;
  endfunction

  // Tap lies inside the image. Coordinates are widened by two bits so that
  // row-1 at row 0 becomes a large value and col+1 at the edge becomes IMG_W;
  // both fail the single unsigned compare instead of wrapping into the image.
  function automatic logic tap_ok(input logic [CRD_W-1:0] row,
                                  input logic [CRD_W-1:0] col,
                                  input logic [3:0]       k);
    logic [3:0]       sel;
    logic [CRD_W+1:0] t_row;
    logic [CRD_W+1:0] t_col;
    sel   = k_sel(k);
    t_row = {2'b00, row} + (CRD_W+2)'(sel[3:2]) - (CRD_W+2)'(1);
    t_col = {2'b00, col} + (CRD_W+2)'(sel[1:0]) - (CRD_W+2)'(1);
    return (t_row < (CRD_W+2)'(IMG_W)) && (t_col < (CRD_W+2)'(IMG_W));
  endfunction

  // Image address of a tap; padded taps read address 0.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [CRD_W-1:0] row,
                                                 input logic [CRD_W-1:0] col,
                                                 input logic [3:0]       k);
    logic [3:0]        sel;
    logic [ADDR_W-1:0] addr;
    sel  = k_sel(k);
    addr = ADDR_W'({row, col});
    case (sel[3:2])
      2'd0:    addr = addr - ADDR_W'(IMG_W);
      2'd2:    addr = addr + ADDR_W'(IMG_W);
      default: addr = addr;
    endcase
    case (sel[1:0])
      2'd0:    addr = addr - ADDR_W'(1);
      2'd2:    addr = addr + ADDR_W'(1);
      default: addr = addr;
    endcase
    return tap_ok(row, col, k) ? addr : '0;
  endfunction

  // Bit k set when tap k of pixel (row, col) is inside the image.
  function automatic logic [8:0] in_range_mask(input logic [CRD_W-1:0] row,
                                               input logic [CRD_W-1:0] col);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = tap_ok(row, col, 4'(i));
    return m;
  endfunction

  // Lowest set index of a tap mask (the centre tap is always set).
  function automatic logic [3:0] first_idx(input logic [8:0] m);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 8; i >= 0; i--) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  // {found, index} of the next set mask bit strictly above k.
  function automatic logic [4:0] next_idx(input logic [8:0] m, input logic [3:0] k);
    logic [4:0] res;
    res = '0;
    for (int i = 8; i >= 0; i--) if (m[i] && (4'(i) > k)) res = {1'b1, 4'(i)};
    return res;
  endfunction

  logic [2:0]       r_state;
  logic [CRD_W-1:0] r_row;
  logic [CRD_W-1:0] r_col;
  logic [3:0]       r_k;
  logic [ADDR_W-1:0] r_iaddr;
  logic             r_tap_vld;
  logic [3:0]       r_tap_idx;
  logic             r_tap_pad;
  logic             r_tap_first;
  logic             r_tap_last;

  logic [2:0]       w_nxt_state;
  logic [CRD_W-1:0] w_nxt_row;
  logic [CRD_W-1:0] w_nxt_col;
  logic [3:0]       w_nxt_k;
  logic [CRD_W-1:0] w_adv_row;
  logic [CRD_W-1:0] w_adv_col;
  logic [8:0]       w_cur_ok;
  logic [8:0]       w_cur_issue;
  logic [8:0]       w_start_issue;
  logic [8:0]       w_adv_issue;
  logic [4:0]       w_next;
  logic             w_last_pix;

  assign w_adv_col  = r_col + 1'b1;
  assign w_adv_row  = (r_col == LP_EDGE) ? r_row + 1'b1 : r_row;
  assign w_last_pix = (r_row == LP_EDGE) && (r_col == LP_EDGE);
  assign w_cur_ok   = in_range_mask(r_row, r_col);

`ifdef CONV_SKIP_PAD_EN
  assign w_cur_issue   = w_cur_ok;
  assign w_start_issue = in_range_mask('0, '0);
  assign w_adv_issue   = in_range_mask(w_adv_row, w_adv_col);
`else
  assign w_cur_issue   = '1;
  assign w_start_issue = '1;
  assign w_adv_issue   = '1;
`endif

  assign w_next = next_idx(w_cur_issue, r_k);

  // Next-state and next-position decode for the scan.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_nxt_state = r_state;
    w_nxt_row   = r_row;
    w_nxt_col   = r_col;
    w_nxt_k     = r_k;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state = S_ISSUE;
          w_nxt_row   = '0;
          w_nxt_col   = '0;
          w_nxt_k     = first_idx(w_start_issue);
        end
      end
      S_ISSUE: begin
        if (w_next[4]) w_nxt_k     = w_next[3:0];
        else           w_nxt_state = S_DRAIN;
      end
      S_DRAIN: w_nxt_state = S_WB_WAIT;
      S_WB_WAIT: begin
        if (wb_ack) begin
          if (w_last_pix) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_ISSUE;
            w_nxt_row   = w_adv_row;
            w_nxt_col   = w_adv_col;
            w_nxt_k     = first_idx(w_adv_issue);
          end
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Scan state, pixel position and tap counter.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_row   <= w_nxt_row;
      r_col   <= w_nxt_col;
      r_k     <= w_nxt_k;
    end
  end

  // Image address register: loaded with the tap about to be issued, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_iaddr <= '0;
    else if (w_nxt_state == S_ISSUE) r_iaddr <= tap_addr(w_nxt_row, w_nxt_col, w_nxt_k);
  end

  // Sample tags: ISSUE-cycle tap attributes delayed one stage to meet idata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tap_vld   <= 1'b0;
      r_tap_idx   <= '0;
      r_tap_pad   <= 1'b0;
      r_tap_first <= 1'b0;
      r_tap_last  <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_tap_vld   <= 1'b1;
      r_tap_idx   <= r_k;
`ifdef CONV_SKIP_PAD_EN
      r_tap_pad   <= 1'b0;
`else
      r_tap_pad   <= ~w_cur_ok[r_k];
`endif
      r_tap_first <= (r_k == first_idx(w_cur_issue));
      r_tap_last  <= ~w_next[4];
    end else begin
      r_tap_vld   <= 1'b0;
      r_tap_idx   <= '0;
      r_tap_pad   <= 1'b0;
      r_tap_first <= 1'b0;
      r_tap_last  <= 1'b0;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign wb_req    = (r_state == S_WB_WAIT);
  assign iaddr     = r_iaddr;
  assign pix_addr  = ADDR_W'({r_row, r_col});
  assign tap_vld   = r_tap_vld;
  assign tap_idx   = r_tap_idx;
  assign tap_pad   = r_tap_pad;
  assign tap_first = r_tap_first;
  assign tap_last  = r_tap_last;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Self-checking bench for conv_tap_sequencer. Expected tap streams come from a
// coordinate-level model of the 3x3 neighbourhood; wb_ack delays and stray
// start/wb_ack pulses are randomised.
module tb_conv_tap_sequencer;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [11:0] iaddr;
  logic        tap_vld;
  logic [3:0]  tap_idx;
  logic        tap_pad;
  logic        tap_first;
  logic        tap_last;
  logic        wb_req;
  logic        wb_ack;
  logic [11:0] pix_addr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int addr;
    int idx;
    bit pad;
  } tap_t;

  tap_t     exp_taps[$];
  int       obs_addr[9];
  int       obs_idx[9];
  bit [8:0] obs_pad;
  bit [8:0] obs_first;
  bit [8:0] obs_last;
  int       obs_n;
  int       obs_pix;

  conv_tap_sequencer #(.IMG_W(64), .ADDR_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .iaddr     (iaddr),
    .tap_vld   (tap_vld),
    .tap_idx   (tap_idx),
    .tap_pad   (tap_pad),
    .tap_first (tap_first),
    .tap_last  (tap_last),
    .wb_req    (wb_req),
    .wb_ack    (wb_ack),
    .pix_addr  (pix_addr)
  );

  always #5 clk = ~clk;

  // Reference: the taps a pixel presents, in order, from plain coordinates.
  task automatic model_pixel(input int r, input int c);
    exp_taps.delete();
    for (int k = 0; k < 9; k++) begin
      int   rr;
      int   cc;
      bit   inb;
      tap_t t;
      rr  = r + k / 3 - 1;
      cc  = c + k % 3 - 1;
      inb = (rr >= 0) && (rr < W) && (cc >= 0) && (cc < W);
`ifdef CONV_SKIP_PAD_EN
      if (inb) begin
        t.addr = rr * W + cc;
        t.idx  = k;
        t.pad  = 1'b0;
        exp_taps.push_back(t);
      end
`else
      t.addr = inb ? rr * W + cc : 0;
      t.idx  = k;
      t.pad  = !inb;
      exp_taps.push_back(t);
`endif
    end
  endtask

  // Entered at the negedge of the pixel's first ISSUE cycle; leaves at the
  // negedge of the cycle after the writeback handshake.
  task automatic run_pixel(input int r, input int c, input int ack_delay);
    int   n;
    tap_t t;
    model_pixel(r, c);
    n       = exp_taps.size();
    obs_n   = 0;
    obs_pad = '0;
    obs_first = '0;
    obs_last  = '0;
    obs_pix = pix_addr;
    for (int cyc = 0; cyc <= n + 1 + ack_delay; cyc++) begin
      n_cmp++;
      if (pix_addr !== 12'(r * W + c) || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL pix_addr/busy (%0d,%0d) cyc %0d: got %0d/%b expected %0d/1", r, c, cyc, pix_addr, busy, r * W + c);
      end
      if (cyc < n) begin
        obs_addr[cyc] = iaddr;
        n_cmp++;
        if (iaddr !== 12'(exp_taps[cyc].addr) || wb_req !== 1'b0) begin
          n_bad++;
          $display("FAIL iaddr (%0d,%0d) cyc %0d: got %0d wb_req %b expected %0d wb_req 0", r, c, cyc, iaddr, wb_req, exp_taps[cyc].addr);
        end
      end else begin
        n_cmp++;
        if (iaddr !== 12'(exp_taps[n-1].addr)) begin
          n_bad++;
          $display("FAIL iaddr_hold (%0d,%0d) cyc %0d: got %0d expected %0d", r, c, cyc, iaddr, exp_taps[n-1].addr);
        end
        n_cmp++;
        if (wb_req !== (cyc >= n + 1)) begin
          n_bad++;
          $display("FAIL wb_req (%0d,%0d) cyc %0d: got %b expected %b", r, c, cyc, wb_req, cyc >= n + 1);
        end
      end
      if (cyc >= 1 && cyc <= n) begin
        t = exp_taps[cyc-1];
        if (tap_vld === 1'b1 && obs_n < 9) begin
          obs_idx[obs_n]   = tap_idx;
          obs_pad[obs_n]   = tap_pad;
          obs_first[obs_n] = tap_first;
          obs_last[obs_n]  = tap_last;
          obs_n++;
        end
        n_cmp++;
        if (tap_vld !== 1'b1 || tap_idx !== 4'(t.idx) || tap_pad !== t.pad ||
            tap_first !== (cyc == 1) || tap_last !== (cyc == n)) begin
          n_bad++;
          $display("FAIL tap (%0d,%0d) cyc %0d: got vld %b idx %0d pad %b first %b last %b expected 1 %0d %b %b %b",
                   r, c, cyc, tap_vld, tap_idx, tap_pad, tap_first, tap_last, t.idx, t.pad, cyc == 1, cyc == n);
        end
      end else begin
        n_cmp++;
        if (tap_vld !== 1'b0) begin
          n_bad++;
          $display("FAIL tap_vld_quiet (%0d,%0d) cyc %0d: got %b expected 0", r, c, cyc, tap_vld);
        end
      end
      // Stray ack/start outside their accepting states must be ignored.
      wb_ack = (cyc <= n) ? 1'($urandom_range(0, 1)) : (cyc == n + 1 + ack_delay);
      start  = (cyc < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    wb_ack = 1'b0;
    start  = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b0;
    wb_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 0 || done !== 0 || wb_req !== 0 || iaddr !== 0 || pix_addr !== 0 ||
        tap_vld !== 0 || tap_idx !== 0 || tap_pad !== 0 || tap_first !== 0 || tap_last !== 0) begin
      n_bad++;
      $display("FAIL reset_values: got busy %b done %b wb_req %b iaddr %0d pix %0d tap %b%0d%b%b%b expected all 0",
               busy, done, wb_req, iaddr, pix_addr, tap_vld, tap_idx, tap_pad, tap_first, tap_last);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 0 || iaddr !== 0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy %b iaddr %0d expected 0 0", busy, iaddr);
    end
  endtask

  task automatic test_corner_pixel();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_pixel(0, 0, 0);
`ifdef CONV_SKIP_PAD_EN
    n_cmp++;
    if (obs_n !== 4 || obs_idx[0] !== 4 || obs_idx[1] !== 5 || obs_idx[2] !== 7 || obs_idx[3] !== 8 ||
        obs_first[0] !== 1'b1 || obs_last[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL corner_skip: got %0d taps idx %0d,%0d,%0d,%0d expected 4 taps idx 4,5,7,8",
               obs_n, obs_idx[0], obs_idx[1], obs_idx[2], obs_idx[3]);
    end
    n_cmp++;
    if (obs_addr[0] !== 0 || obs_addr[1] !== 1 || obs_addr[2] !== 64 || obs_addr[3] !== 65) begin
      n_bad++;
      $display("FAIL corner_addr: got %0d %0d %0d %0d expected 0 1 64 65", obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]);
    end
`else
    n_cmp++;
    if (obs_n !== 9 || obs_pad !== 9'b001001111) begin
      n_bad++;
      $display("FAIL corner_pad: got %0d taps pads %b (bit k) expected 9 taps 001001111", obs_n, obs_pad);
    end
    n_cmp++;
    if (obs_addr[4] !== 0 || obs_addr[5] !== 1 || obs_addr[7] !== 64 || obs_addr[8] !== 65 ||
        obs_addr[0] !== 0 || obs_addr[1] !== 0 || obs_addr[2] !== 0 || obs_addr[3] !== 0 || obs_addr[6] !== 0) begin
      n_bad++;
      $display("FAIL corner_addr: got k4 %0d k5 %0d k7 %0d k8 %0d pads %0d %0d %0d %0d %0d expected 0 1 64 65 and 0s",
               obs_addr[4], obs_addr[5], obs_addr[7], obs_addr[8], obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3], obs_addr[6]);
    end
`endif
  endtask

  task automatic test_interior_pixel();
    int exp_seq[9];
    exp_seq = '{595, 596, 597, 659, 660, 661, 723, 724, 725};
    for (int p = 1; p < 660; p++) run_pixel(p / W, p % W, $urandom_range(0, 2));
    run_pixel(10, 20, 0);
    n_cmp++;
    if (obs_pix !== 660) begin
      n_bad++;
      $display("FAIL interior_pix: got %0d expected 660", obs_pix);
    end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (obs_addr[k] !== exp_seq[k] || obs_idx[k] !== k || obs_pad[k] !== 1'b0 ||
          obs_first[k] !== (k == 0) || obs_last[k] !== (k == 8)) begin
        n_bad++;
        $display("FAIL interior_tap k%0d: got addr %0d idx %0d pad %b first %b last %b expected %0d %0d 0 %b %b",
                 k, obs_addr[k], obs_idx[k], obs_pad[k], obs_first[k], obs_last[k], exp_seq[k], k, k == 0, k == 8);
      end
    end
  endtask

  task automatic test_wb_stall();
    run_pixel(10, 21, 5);
  endtask

  task automatic test_reset_mid_frame();
    model_pixel(10, 22);
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 0) begin
        n_cmp++;
        if (iaddr !== 12'(exp_taps[0].addr)) begin
          n_bad++;
          $display("FAIL next_pixel_k0: got %0d expected %0d", iaddr, exp_taps[0].addr);
        end
      end
      if (cyc == 1) begin
        n_cmp++;
        if (tap_vld !== 1 || tap_idx !== 0 || tap_first !== 1) begin
          n_bad++;
          $display("FAIL next_pixel_first: got vld %b idx %0d first %b expected 1 0 1", tap_vld, tap_idx, tap_first);
        end
      end
      start = (cyc == 2);
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (iaddr !== 12'(exp_taps[4].addr) || tap_idx !== 4'd3) begin
      n_bad++;
      $display("FAIL start_while_busy: got iaddr %0d idx %0d expected %0d 3", iaddr, tap_idx, exp_taps[4].addr);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 0 || done !== 0 || wb_req !== 0 || iaddr !== 0 || pix_addr !== 0 ||
        tap_vld !== 0 || tap_idx !== 0 || tap_pad !== 0 || tap_first !== 0 || tap_last !== 0) begin
      n_bad++;
      $display("FAIL async_reset: got busy %b done %b wb_req %b iaddr %0d pix %0d tap %b%0d%b%b%b expected all 0",
               busy, done, wb_req, iaddr, pix_addr, tap_vld, tap_idx, tap_pad, tap_first, tap_last);
    end
    start = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 0 || iaddr !== 0) begin
      n_bad++;
      $display("FAIL idle_after_abort: got busy %b iaddr %0d expected 0 0", busy, iaddr);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_pixel(0, 0, 1);
  endtask

  task automatic test_full_frame();
    int total;
    int cyc;
    int hs;
    int pix_bad;
    int last_pix;
    int done_cnt;
    int done_cyc;
    bit finished;
    total = 0;
    for (int p = 0; p < W * W; p++) begin
      model_pixel(p / W, p % W);
      total += exp_taps.size() + 2;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wb_ack = 1'b1;
    cyc = 0; hs = 0; pix_bad = 0; last_pix = -1; done_cnt = 0; done_cyc = -1; finished = 1'b0;
    while (!finished && cyc < total + 100) begin
      if (wb_req === 1'b1) begin
        if (pix_addr !== 12'(hs)) pix_bad++;
        last_pix = pix_addr;
        hs++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_at_done: got %b expected 1", busy);
        end
      end else if (done_cnt > 0) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_after_done: got %b expected 0", busy);
        end
        finished = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    wb_ack = 1'b0;
    repeat (20) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL frame_timeout: got no done within %0d cycles expected done at %0d", total + 100, total);
    end
    n_cmp++;
    if (hs !== W * W || last_pix !== W * W - 1 || pix_bad !== 0) begin
      n_bad++;
      $display("FAIL frame_handshakes: got %0d last pix %0d bad pix %0d expected %0d last %0d bad 0", hs, last_pix, pix_bad, W * W, W * W - 1);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== total) begin
      n_bad++;
      $display("FAIL frame_done: got %0d pulses at cycle %0d expected 1 at %0d", done_cnt, done_cyc, total);
    end
  endtask

  initial begin
    test_reset();
    test_corner_pixel();
    test_interior_pixel();
    test_wb_stall();
    test_reset_mid_frame();
    test_full_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_tap_sequencer.md
# conv_tap_sequencer

Scan controller for the 3x3 zero-padded convolution datapath. Walks every output pixel of a 64x64 greyscale image in row-major order and issues the nine kernel-tap image addresses per pixel, with zero-pad flags. Tags each returned `idata` sample for the MAC/ReLU datapath and holds the scan until that datapath acknowledges the layer-0 writeback of the finished pixel. Sits between the top-level ready/busy handshake and the MAC datapath, and owns `iaddr`.

## Interface
- `IMG_W`, 64, image width and height in pixels; power of two.
- `ADDR_W`, 12, address width; log2(IMG_W*IMG_W).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle pulse to begin a frame; ignored unless idle.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse after the final pixel's writeback is acknowledged.
- `iaddr` out ADDR_W: image read address, registered.
- `tap_vld` out 1: `idata` this cycle belongs to a tap; aligned one cycle after its `iaddr`.
- `tap_idx` out 4: kernel index 0..8 of the current sample.
- `tap_pad` out 1: tap falls outside the image; datapath uses 0 instead of `idata`.
- `tap_first` out 1: first tap of the pixel; accumulator loads bias plus product.
- `tap_last` out 1: last tap of the pixel.
- `wb_req` out 1: pixel result ready for ReLU and layer-0 write.
- `wb_ack` in 1: datapath has written the pixel.
- `pix_addr` out ADDR_W: current output pixel address, row*IMG_W+col; used as `caddr_wr`.

## Operation
- States: IDLE, ISSUE, DRAIN, WB_WAIT, DONE.
- IDLE: if `start`, clear row, col and k, then go to ISSUE.
- ISSUE: one tap per cycle, k = 0..8.
  - dr = k/3−1, dc = k%3−1; tap at (row+dr, col+dc).
  - In range: `iaddr` = (row+dr)*IMG_W + (col+dc), `tap_pad` = 0.
  - Out of range: `iaddr` = 0, `tap_pad` = 1.
  - After the last tap, go to DRAIN.
- DRAIN: one cycle while the last sample returns, then WB_WAIT.
- WB_WAIT: `wb_req` = 1; `iaddr` and `pix_addr` hold. When `wb_ack` = 1:
  - If pix_addr = IMG_W*IMG_W−1, go to DONE.
  - Otherwise advance col, or wrap col to 0 and increment row, then return to ISSUE with k = 0.
- DONE: `done` = 1 and `busy` = 1 for one cycle, then IDLE.
- `tap_vld`, `tap_idx`, `tap_pad`, `tap_first`, `tap_last` are the ISSUE-cycle values delayed one register stage.
- `wb_ack` outside WB_WAIT is ignored. `start` outside IDLE is ignored.
- Bounds checks use signed or extended arithmetic: row−1 at row 0 and col+1 at col IMG_W−1 must flag pad, never wrap the address.

## Timing
- Reset values: `busy`, `done`, `tap_*`, `wb_req` = 0; `iaddr`, `pix_addr` = 0. Reset mid-frame aborts immediately to IDLE with these values. The next `start` restarts at pixel 0.
- Per pixel with `wb_ack` tied high: 9 ISSUE + 1 DRAIN + 1 WB_WAIT = 11 cycles.
- Frame: 4096*11 = 45056 cycles from first ISSUE to DONE.
- `tap_vld` for tap k is high in the cycle after `iaddr` for tap k. The `tap_last` sample is presented in the DRAIN cycle.
- `wb_req` rises the cycle after DRAIN. It falls the cycle after `wb_ack` is sampled high.

## Configuration
- `CONV_SKIP_PAD_EN` defined: padded taps are not issued.
  - ISSUE advances k past out-of-range taps in the same cycle.
  - `tap_pad` is always 0.
  - `tap_first` and `tap_last` mark the first and last in-range taps.
  - Taps per pixel: 4 at corners, 6 on edges, 9 in the interior.
- Not defined: all 9 taps are always issued, with `tap_pad` flagging the padded ones.

## Test plan
- Start, pixel (0,0): `tap_pad` per k = 1,1,1,1,0,0,1,0,0. `iaddr` for k = 4,5,7,8 is 0, 1, 64, 65; `iaddr` is 0 for the padded taps.
- Pixel (10,20), interior: `iaddr` sequence is 595, 596, 597, 659, 660, 661, 723, 724, 725, with no pad. `tap_first` is on k=0, `tap_last` on k=8. `pix_addr` = 660.
- `wb_ack` held low for 5 cycles in WB_WAIT: `wb_req` stays high, `iaddr` and `pix_addr` are stable, `tap_vld` = 0. After the ack, the next pixel starts at k = 0.
- Full frame with `wb_ack` tied high:
  - exactly 4096 `wb_req` handshakes;
  - last `pix_addr` = 4095;
  - a single `done` pulse 45056 cycles after the first ISSUE;
  - `busy` falls the cycle after `done`.
- Reset asserted in ISSUE at k = 4: all outputs return to reset values asynchronously. A `start` pulse while busy is ignored. A fresh `start` after reset reissues pixel 0.
- With `CONV_SKIP_PAD_EN`:
  - pixel (0,0) issues k = 4, 5, 7, 8 only, `tap_first` on k = 4, `tap_last` on k = 8, 4+1+1 = 6 cycles;
  - pixel (0,5) issues 6 taps;
  - pixel (63,63) issues k = 0, 1, 3, 4.
